// File: rtl/background_writer.sv
// Write-side engine for the background RAM: turns rectangle commands into a column-major
// stream of RAM writes, either as a solid fill or from pixels supplied over a handshake.
module background_writer #(
    parameter int NUMBER_COLORS = 10,
    parameter int WIDTH         = 320,
    parameter int HEIGHT        = 240,
    localparam int CW           = $clog2(NUMBER_COLORS) + 1,
    localparam int AW           = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_mode,
    input  logic [8:0]    cmd_x0,
    input  logic [7:0]    cmd_y0,
    input  logic [8:0]    cmd_x1,
    input  logic [7:0]    cmd_y1,
    input  logic [CW-1:0] cmd_color,
    input  logic          abort,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [CW-1:0] pix_data,
    output logic [AW-1:0] waddr,
    output logic [CW-1:0] din,
    output logic          we,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t        state, state_next;
    logic [8:0]    x_pos, x_hi;
    logic [7:0]    y_pos, y_lo, y_hi;
    logic [CW-1:0] color;

    logic          accept, cmd_ok, write_now, is_last;
    logic [8:0]    cur_x, bx1, nx;
    logic [7:0]    cur_y, by0, by1, ny;
    logic [AW-1:0] cur_addr;
    logic [CW-1:0] cur_data;

    assign cmd_ready = (state == IDLE);
    assign busy      = !cmd_ready;
    // Once the final pixel has been taken, stop offering ready while done is shown.
    assign pix_ready = (state == STREAM) && !done;

    // In IDLE the command inputs stand in for the latched bounds, so a fill can
    // issue its first write on the same edge it is accepted.
    always_comb begin
        accept   = cmd_valid && (state == IDLE);
        cmd_ok   = (cmd_x0 <= cmd_x1) && (int'(cmd_x1) < WIDTH) &&
                   (cmd_y0 <= cmd_y1) && (int'(cmd_y1) < HEIGHT);
        cur_x    = x_pos;
        cur_y    = y_pos;
        bx1      = x_hi;
        by0      = y_lo;
        by1      = y_hi;
        cur_data = color;
        if (state == IDLE) begin
            cur_x    = cmd_x0;
            cur_y    = cmd_y0;
            bx1      = cmd_x1;
            by0      = cmd_y0;
            by1      = cmd_y1;
            cur_data = cmd_color;
        end else if (state == STREAM) begin
            cur_data = pix_data;
        end
        is_last  = (cur_x == bx1) && (cur_y == by1);
        nx       = cur_x;
        ny       = cur_y + 8'd1;
        if (cur_y == by1) begin
            nx = cur_x + 9'd1;
            ny = by0;
        end
        cur_addr = AW'(cur_y) + AW'(HEIGHT) * AW'(cur_x);
    end

    always_comb begin
        state_next = state;
        write_now  = 1'b0;
        case (state)
            IDLE: begin
                write_now = accept && cmd_ok && !cmd_mode;
                if (accept && cmd_ok)
                    state_next = cmd_mode ? STREAM : FILL;
            end
            FILL: begin
                write_now = !done && !abort;
                if (done || abort)
                    state_next = IDLE;
            end
            STREAM: begin
                write_now = pix_valid && !done && !abort;
                if (done || abort)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Position registers always hold the next pixel to be written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= '0;
            y_pos <= '0;
            x_hi  <= '0;
            y_lo  <= '0;
            y_hi  <= '0;
            color <= '0;
            waddr <= '0;
            din   <= '0;
            we    <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            we   <= write_now;
            done <= write_now && is_last;
            err  <= accept && !cmd_ok;
            if (accept && cmd_ok) begin
                x_hi  <= cmd_x1;
                y_lo  <= cmd_y0;
                y_hi  <= cmd_y1;
                color <= cmd_color;
                x_pos <= cmd_mode ? cmd_x0 : nx;
                y_pos <= cmd_mode ? cmd_y0 : ny;
            end else if (write_now) begin
                x_pos <= nx;
                y_pos <= ny;
            end
            if (write_now) begin
                waddr <= cur_addr;
                din   <= cur_data;
            end
        end
    end

endmodule

// File: tb/tb_background_writer.sv
// Directed bench for background_writer: fills, gapped stream, rejects, abort and reset.
module tb_background_writer;

    localparam int CW = 5;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_mode = 1'b0;
    logic [8:0]    cmd_x0 = '0;
    logic [7:0]    cmd_y0 = '0;
    logic [8:0]    cmd_x1 = '0;
    logic [7:0]    cmd_y1 = '0;
    logic [CW-1:0] cmd_color = '0;
    logic          abort = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [CW-1:0] pix_data = '0;
    logic [AW-1:0] waddr;
    logic [CW-1:0] din;
    logic          we;
    logic          busy;
    logic          done;
    logic          err;

    int test_count = 0;
    int fail_count = 0;
    int seen_count;
    int full_bad;
    int fill_addr [4] = '{483, 484, 723, 724};

    background_writer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .waddr(waddr), .din(din), .we(we), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accept edge.
    task automatic applyStimulus(input logic mode, input logic [8:0] x0, input logic [7:0] y0,
                                 input logic [8:0] x1, input logic [7:0] y1,
                                 input logic [CW-1:0] color);
        cmd_mode  = mode;
        cmd_x0    = x0;
        cmd_y0    = y0;
        cmd_x1    = x1;
        cmd_y1    = y1;
        cmd_color = color;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_we", 32'(we), 0);
        checkOutput("rst_waddr", 32'(waddr), 0);
        checkOutput("rst_din", 32'(din), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_pix_ready", 32'(pix_ready), 0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;

        // Stray pixels and abort while idle must do nothing.
        seen_count = 0;
        pix_valid  = 1'b1;
        abort      = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (we || pix_ready || !cmd_ready) seen_count++;
        end
        pix_valid = 1'b0;
        abort     = 1'b0;
        checkOutput("idle_quiet", 32'(seen_count), 0);

        applyStimulus(1'b0, 9'd2, 8'd3, 9'd3, 8'd4, 5'd5);
        checkOutput("fill_busy", 32'(busy), 1);
        checkOutput("fill_cmd_ready", 32'(cmd_ready), 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("fill_we", 32'(we), 1);
            checkOutput("fill_addr", 32'(waddr), 32'(fill_addr[i]));
            checkOutput("fill_din", 32'(din), 5);
            checkOutput("fill_done", 32'(done), (i == 3) ? 1 : 0);
            @(negedge clk);
        end
        checkOutput("fill_end_we", 32'(we), 0);
        checkOutput("fill_end_done", 32'(done), 0);
        checkOutput("fill_end_ready", 32'(cmd_ready), 1);

        applyStimulus(1'b0, 9'd0, 8'd0, 9'd319, 8'd239, 5'd0);
        full_bad = 0;
        for (int i = 0; i < 76800; i++) begin
            if (we !== 1'b1 || waddr !== 17'(i) || din !== 5'd0 || done !== (i == 76799))
                full_bad++;
            @(negedge clk);
        end
        checkOutput("full_bad_writes", 32'(full_bad), 0);
        checkOutput("full_end_we", 32'(we), 0);
        checkOutput("full_end_ready", 32'(cmd_ready), 1);

        applyStimulus(1'b1, 9'd0, 8'd0, 9'd0, 8'd2, 5'd0);
        checkOutput("stream_pix_ready", 32'(pix_ready), 1);
        checkOutput("stream_start_we", 32'(we), 0);
        @(negedge clk);
        checkOutput("stream_gap_we", 32'(we), 0);
        for (int p = 1; p <= 3; p++) begin
            pix_valid = 1'b1;
            pix_data  = CW'(p);
            @(negedge clk);
            pix_valid = 1'b0;
            checkOutput("stream_we", 32'(we), 1);
            checkOutput("stream_addr", 32'(waddr), 32'(p - 1));
            checkOutput("stream_din", 32'(din), 32'(p));
            checkOutput("stream_done", 32'(done), (p == 3) ? 1 : 0);
            if (p < 3) begin
                @(negedge clk);
                checkOutput("stream_hold_we", 32'(we), 0);
                checkOutput("stream_hold_ready", 32'(pix_ready), 1);
            end
        end
        checkOutput("stream_ready_off", 32'(pix_ready), 0);
        @(negedge clk);
        checkOutput("stream_end_ready", 32'(cmd_ready), 1);
        checkOutput("stream_end_we", 32'(we), 0);

        applyStimulus(1'b0, 9'd0, 8'd0, 9'd320, 8'd0, 5'd1);
        checkOutput("bad_x1_err", 32'(err), 1);
        checkOutput("bad_x1_we", 32'(we), 0);
        checkOutput("bad_x1_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        checkOutput("bad_err_pulse", 32'(err), 0);
        applyStimulus(1'b0, 9'd5, 8'd0, 9'd4, 8'd0, 5'd1);
        checkOutput("bad_order_err", 32'(err), 1);
        checkOutput("bad_order_we", 32'(we), 0);
        @(negedge clk);
        applyStimulus(1'b1, 9'd0, 8'd0, 9'd0, 8'd240, 5'd1);
        checkOutput("bad_y1_err", 32'(err), 1);
        checkOutput("bad_y1_ready", 32'(cmd_ready), 1);
        @(negedge clk);

        applyStimulus(1'b0, 9'd0, 8'd0, 9'd0, 8'd9, 5'd4);
        for (int i = 0; i < 3; i++) begin
            checkOutput("abort_pre_we", 32'(we), 1);
            checkOutput("abort_pre_addr", 32'(waddr), 32'(i));
            if (i < 2) @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_we", 32'(we), 0);
        checkOutput("abort_done", 32'(done), 0);
        checkOutput("abort_ready", 32'(cmd_ready), 1);
        seen_count = 0;
        repeat (3) begin
            @(negedge clk);
            if (we || done) seen_count++;
        end
        checkOutput("abort_quiet", 32'(seen_count), 0);
        applyStimulus(1'b0, 9'd7, 8'd7, 9'd7, 8'd7, 5'd9);
        checkOutput("after_abort_we", 32'(we), 1);
        checkOutput("after_abort_addr", 32'(waddr), 1687);
        checkOutput("after_abort_din", 32'(din), 9);
        checkOutput("after_abort_done", 32'(done), 1);
        @(negedge clk);

        applyStimulus(1'b0, 9'd1, 8'd0, 9'd1, 8'd9, 5'd3);
        checkOutput("mid_rst_addr0", 32'(waddr), 240);
        @(negedge clk);
        checkOutput("mid_rst_addr1", 32'(waddr), 241);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_we", 32'(we), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_done", 32'(done), 0);
        checkOutput("mid_rst_ready", 32'(cmd_ready), 1);
        checkOutput("mid_rst_waddr", 32'(waddr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 9'd0, 8'd5, 9'd0, 8'd5, 5'd2);
        checkOutput("after_rst_we", 32'(we), 1);
        checkOutput("after_rst_addr", 32'(waddr), 5);
        checkOutput("after_rst_din", 32'(din), 2);
        checkOutput("after_rst_done", 32'(done), 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
